bram_fifo_ctrl: RTL

- Streaming FIFO controller that uses an external synchronous dual-port BRAM as its storage array.
- Port A is the write-only side and port B is the read-only side. The BRAM has 1-cycle registered read latency.
- Upstream producers push through a valid/ready handshake; downstream consumers see first-word-fall-through valid/ready output.
- A 2-entry output skid buffer hides the BRAM read latency, so steady-state throughput is 1 word/cycle.

---
 rtl/bram_fifo_pkg.sv | 19 +
 rtl/bram_fifo_ctrl_if.sv | 35 +++
 rtl/fifo_skid2.sv | 63 ++++++
 rtl/bram_fifo_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared types and sizing helpers for the BRAM-backed streaming FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bram_fifo_pkg;

    // Skid buffer occupancy: 0, 1 or 2 words.
    typedef logic [1:0] skid_occ_t;

    localparam int SKID_ENTRIES       = 2;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    // BRAM depth for a given address width.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int DEFAULT_DEPTH = depth_of(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Bundle of the stream push side, stream pop side and both BRAM ports of the FIFO controller.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles producers, out_ready throttles the controller's output.
// master = controller side, slave = producer/consumer/BRAM environment.
interface bram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  clr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH+1:0] count;
    logic                  mem_we_a;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_din_a;
    logic                  mem_we_b;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [DATA_WIDTH-1:0] mem_dout_b;

    modport master (
        input  clr, in_data, in_valid, out_ready, mem_dout_b,
        output in_ready, out_data, out_valid, count,
               mem_we_a, mem_addr_a, mem_din_a, mem_we_b, mem_addr_b
    );

    modport slave (
        output clr, in_data, in_valid, out_ready, mem_dout_b,
        input  in_ready, out_data, out_valid, count,
               mem_we_a, mem_addr_a, mem_din_a, mem_we_b, mem_addr_b
    );
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry registered skid buffer that catches BRAM read data; head word is out_data.
// Latency: a word pushed in cycle N is visible at the head in cycle N+1 (if the buffer was empty).
// Backpressure: none internally; the caller must never push into a full buffer without a pop.
// Ports: clk/reset, clr (sync flush), push/push_data (tail write), pop (head advance),
//        occ (0..2), head_data (registered head word).
module fifo_skid2
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output skid_occ_t             occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] d0;   // head
    logic [DATA_WIDTH-1:0] d1;   // second entry

    assign head_data = d0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ <= '0;
            d0  <= '0;
            d1  <= '0;
        end else if (clr) begin
            // Flush wins over a capture in the same cycle: returning data is dropped.
            occ <= '0;
        end else begin
            unique case ({push, pop})
                2'b11: begin
                    // Occupancy unchanged; the head advances and the new word joins the tail.
                    if (occ == 2'd1) begin
                        d0 <= push_data;
                    end else begin
                        d0 <= d1;
                        d1 <= push_data;
                    end
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        d0  <= push_data;
                        occ <= 2'd1;
                    end else if (occ == 2'd1) begin
                        d1  <= push_data;
                        occ <= 2'd2;
                    end
                end
                2'b01: begin
                    d0  <= d1;
                    occ <= occ - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller over an external 1-cycle-latency dual-port BRAM, FWFT output via a skid buffer.
// Latency: push in cycle N -> out_valid in cycle N+3 from empty; sustains 1 word/cycle once filled.
// Backpressure: in_ready drops when the BRAM holds DEPTH words; out_ready stalls reads, skid absorbs the in-flight word.
// Ports: clk, reset (async, active-high), bus (master modport): clr, in_*, out_*, count, BRAM ports A (write) and B (read).
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    bram_fifo_ctrl_if.master bus
);

    localparam int                  DEPTH     = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;    // words resident in the BRAM only
    logic                  rd_inflight;  // a read issued last cycle returns on mem_dout_b now
    skid_occ_t             occ;
    logic [DATA_WIDTH-1:0] skid_head;

    logic                  in_ready;
    logic                  out_valid;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            slots;

    // Reset is folded in combinationally so in_ready is low while reset is held
    // and high from the very first cycle after it is released.
    assign in_ready  = ~reset & (mem_count != DEPTH_CNT) & ~bus.clr;
    assign push      = bus.in_valid & in_ready;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & bus.out_ready;

    // Words that will sit in the skid after this cycle if no new read is issued;
    // a read is only issued when its return is guaranteed a free skid slot.
    assign slots = 3'(occ) + 3'(rd_inflight) - 3'(pop);
    assign issue = (mem_count != '0) & (slots < 3'(SKID_ENTRIES)) & ~bus.clr;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = skid_head;
    assign bus.mem_we_a   = push;
    assign bus.mem_addr_a = wr_ptr;
    assign bus.mem_din_a  = bus.in_data;
    assign bus.mem_we_b   = 1'b0;
    assign bus.mem_addr_b = rd_ptr;
    assign bus.count      = (ADDR_WIDTH+2)'(mem_count) + (ADDR_WIDTH+2)'(rd_inflight)
                          + (ADDR_WIDTH+2)'(occ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
            rd_inflight <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
            rd_inflight <= 1'b0;
        end else begin
            // Pointers wrap through natural ADDR_WIDTH overflow.
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            unique case ({push, issue})
                2'b10:   mem_count <= mem_count + (ADDR_WIDTH+1)'(1);
                2'b01:   mem_count <= mem_count - (ADDR_WIDTH+1)'(1);
                default: ;
            endcase
            rd_inflight <= issue;
        end
    end

    // Capture BRAM read data into the skid tail the cycle it arrives.
    fifo_skid2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clr       (bus.clr),
        .push      (rd_inflight),
        .push_data (bus.mem_dout_b),
        .pop       (pop),
        .occ       (occ),
        .head_data (skid_head)
    );

endmodule
